// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, branch squash/redirect, branch watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module id_hazard_ctrl #(
    parameter int BR_TIMEOUT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      IR,
    input  logic             IR_VALID,
    input  logic [1:0]       OP_EX,
    input  logic [2:0]       DR_EX,
    input  logic             EX_VALID,
    input  logic             BR_RESOLVE,
    input  logic             BR_TAKEN,
    output logic             PC_WRITE,
    output logic             PC_SEL,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             ID_BUBBLE,
    output logic [1:0]       STATE,
    output logic             ERR,
    output logic [CNT_W-1:0] LDUSE_CNT,
    output logic [CNT_W-1:0] BR_CNT
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_RSVD    = 2'b01,
        ST_BR_WAIT = 2'b10,
        ST_ERR     = 2'b11
    } state_e;

    localparam logic [3:0] OPC_BR  = 4'b0000;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_LDW = 4'b0110;
    localparam logic [3:0] OPC_STW = 4'b0111;
    localparam logic [1:0] EX_LDW  = 2'b10;
    localparam logic [3:0] WD_LOAD = 4'(BR_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] wd_q, wd_d;

    logic [3:0] opcode;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       is_add;
    logic       is_ldw;
    logic       is_stw;
    logic       sr1_used;
    logic       sr2_used;
    logic       brd;
    logic       lud;

    logic       pc_write;
    logic       pc_sel;
    logic       ifid_write;
    logic       ifid_flush;
    logic       id_bubble;

    // ------------------------------------------------------------------
    // Instruction decode and hazard detection
    // ------------------------------------------------------------------
    assign opcode   = IR[15:12];
    assign sr1      = IR[8:6];
    assign is_add   = (opcode == OPC_ADD);
    assign is_ldw   = (opcode == OPC_LDW);
    assign is_stw   = (opcode == OPC_STW);
    assign sr2      = is_stw ? IR[11:9] : IR[2:0];
    assign sr1_used = is_add | is_ldw | is_stw;
    assign sr2_used = is_stw | (is_add & ~IR[5]);

    assign brd = IR_VALID && (opcode == OPC_BR) && (IR != 16'h0000);

    // Only a load in EX can't be forwarded in time; ADD results already reach ID.
    assign lud = IR_VALID && EX_VALID && (OP_EX == EX_LDW) && !brd &&
                 ((sr1_used && (DR_EX == sr1)) || (sr2_used && (DR_EX == sr2)));

    // ------------------------------------------------------------------
    // FSM: next state, watchdog and Mealy controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        pc_write   = 1'b1;
        pc_sel     = 1'b0;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        id_bubble  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (brd) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    wd_d       = WD_LOAD;
                    state_d    = ST_BR_WAIT;
                end else if (lud) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    id_bubble  = 1'b1;
                end
            end

            ST_BR_WAIT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                id_bubble  = 1'b1;
                if (BR_RESOLVE) begin
                    pc_write = 1'b1;
                    pc_sel   = BR_TAKEN;
                    wd_d     = 4'd0;
                    state_d  = ST_RUN;
                end else if (wd_q <= 4'd1) begin
                    // Last permitted wait cycle passed without a resolve.
                    wd_d    = 4'd0;
                    state_d = ST_ERR;
                end else begin
                    wd_d = wd_q - 4'd1;
                end
            end

            ST_ERR: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                id_bubble  = 1'b1;
            end

            default: begin
                // Unused encoding: hold the pipe for one cycle and fall back to RUN.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                id_bubble  = 1'b1;
                wd_d       = 4'd0;
                state_d    = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
            wd_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Reset overrides the Mealy path so outputs are clean while RESET is high.
    assign PC_WRITE   = RESET ? 1'b1 : pc_write;
    assign PC_SEL     = RESET ? 1'b0 : pc_sel;
    assign IFID_WRITE = RESET ? 1'b1 : ifid_write;
    assign IFID_FLUSH = RESET ? 1'b0 : ifid_flush;
    assign ID_BUBBLE  = RESET ? 1'b0 : id_bubble;
    assign STATE      = state_q;
    assign ERR        = (state_q == ST_ERR);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] cnt_inc;

    assign cnt_inc[0] = (state_q == ST_RUN) && lud;
    assign cnt_inc[1] = (state_q == ST_BR_WAIT);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && !(&cnt_q)) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign LDUSE_CNT = g_cnt[0].cnt_q;
    assign BR_CNT    = g_cnt[1].cnt_q;
`else
    assign LDUSE_CNT = '0;
    assign BR_CNT    = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed testbench for id_hazard_ctrl: load-use stalls, branch resolve/timeout, async reset.
module tb_id_hazard_ctrl;

    localparam int CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Packed expected controls: {PC_WRITE, PC_SEL, IFID_WRITE, IFID_FLUSH, ID_BUBBLE, STATE[1:0], ERR}
    localparam logic [7:0] O_RUN   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam logic [7:0] O_LUD   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam logic [7:0] O_BRD   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    localparam logic [7:0] O_WAIT  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    localparam logic [7:0] O_RES_T = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    localparam logic [7:0] O_RES_N = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    localparam logic [7:0] O_ERR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1};

    logic             CLK = 1'b0;
    logic             RESET;
    logic [15:0]      IR;
    logic             IR_VALID;
    logic [1:0]       OP_EX;
    logic [2:0]       DR_EX;
    logic             EX_VALID;
    logic             BR_RESOLVE;
    logic             BR_TAKEN;
    logic             PC_WRITE;
    logic             PC_SEL;
    logic             IFID_WRITE;
    logic             IFID_FLUSH;
    logic             ID_BUBBLE;
    logic [1:0]       STATE;
    logic             ERR;
    logic [CNT_W-1:0] LDUSE_CNT;
    logic [CNT_W-1:0] BR_CNT;

    int n_assert = 0;
    int n_fail   = 0;
    int ld_exp   = 0;
    int br_exp   = 0;

    id_hazard_ctrl #(.BR_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IR         (IR),
        .IR_VALID   (IR_VALID),
        .OP_EX      (OP_EX),
        .DR_EX      (DR_EX),
        .EX_VALID   (EX_VALID),
        .BR_RESOLVE (BR_RESOLVE),
        .BR_TAKEN   (BR_TAKEN),
        .PC_WRITE   (PC_WRITE),
        .PC_SEL     (PC_SEL),
        .IFID_WRITE (IFID_WRITE),
        .IFID_FLUSH (IFID_FLUSH),
        .ID_BUBBLE  (ID_BUBBLE),
        .STATE      (STATE),
        .ERR        (ERR),
        .LDUSE_CNT  (LDUSE_CNT),
        .BR_CNT     (BR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [15:0] ir, input logic iv, input logic ev,
                         input logic [1:0] op, input logic [2:0] dr,
                         input logic rs, input logic rt);
        IR         = ir;
        IR_VALID   = iv;
        EX_VALID   = ev;
        OP_EX      = op;
        DR_EX      = dr;
        BR_RESOLVE = rs;
        BR_TAKEN   = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_o(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, PC_WRITE, PC_SEL, IFID_WRITE, IFID_FLUSH, ID_BUBBLE, STATE, ERR}, {24'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_ld"}, {16'd0, LDUSE_CNT}, PERF ? ld_exp : 0);
        chk({tag, "_br"}, {16'd0, BR_CNT}, PERF ? br_exp : 0);
    endtask

    initial begin
        // Reset held with a load-use pattern present: outputs must still show reset values
        RESET = 1'b1;
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("reset_out", O_RUN);
        chk_cnt("reset_cnt");
        tick();
        RESET = 1'b0;
        drive(16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("idle_run", O_RUN);
        tick();

        // Load-use cases
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("add_sr1_stall", O_LUD);
        tick(); ld_exp++;
        drive(16'h1283, 1'b1, 1'b0, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("after_bubble", O_RUN);
        chk_cnt("ld1");
        tick();
        drive(16'h12A3, 1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0);
        chk_o("addimm_nostall", O_RUN);
        tick();
        drive(16'h12A3, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("addimm_sr1", O_LUD);
        tick(); ld_exp++;
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0);
        chk_o("add_sr2_stall", O_LUD);
        tick(); ld_exp++;
        drive(16'h1283, 1'b1, 1'b1, 2'b01, 3'd2, 1'b0, 1'b0);
        chk_o("ex_add_fwd", O_RUN);
        tick();
        drive(16'h1283, 1'b1, 1'b0, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("ex_invalid", O_RUN);
        tick();
        drive(16'h1283, 1'b0, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("ir_invalid", O_RUN);
        tick();
        drive(16'h7A80, 1'b1, 1'b1, 2'b10, 3'd5, 1'b0, 1'b0);
        chk_o("stw_sr2_stall", O_LUD);
        tick(); ld_exp++;
        drive(16'h7A80, 1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0);
        chk_o("stw_low_nostall", O_RUN);
        tick();
        drive(16'h62C0, 1'b1, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0);
        chk_o("ldw_sr1_stall", O_LUD);
        tick(); ld_exp++;
        drive(16'h62C0, 1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0);
        chk_o("ldw_nosr2", O_RUN);
        chk_cnt("ld5");
        tick();

        // Branch resolved taken at k=2; same-cycle resolve with BRD is ignored
        drive(16'h0405, 1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 1'b1);
        chk_o("br1_detect", O_BRD);
        tick();
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("br1_wait", O_WAIT);
        tick(); br_exp++;
        drive(16'h0000, 1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 1'b1);
        chk_o("br1_resolve", O_RES_T);
        tick(); br_exp++;
        drive(16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("br1_run", O_RUN);
        chk_cnt("br1");
        tick();

        // Branch resolved not-taken at the last allowed cycle (k=4)
        drive(16'h0405, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("br2_detect", O_BRD);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(16'h0000, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
            chk_o($sformatf("br2_wait%0d", i), O_WAIT);
            tick(); br_exp++;
        end
        drive(16'h0000, 1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0);
        chk_o("br2_resolve", O_RES_N);
        tick(); br_exp++;
        drive(16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("br2_run", O_RUN);
        chk_cnt("br2");
        tick();

        // Branch never resolves: ERR five cycles after BRD, sticky until reset
        drive(16'h0405, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("br3_detect", O_BRD);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(16'h0000, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
            chk_o($sformatf("br3_wait%0d", i), O_WAIT);
            tick(); br_exp++;
        end
        drive(16'h0000, 1'b1, 1'b0, 2'b00, 3'd0, 1'b1, 1'b1);
        chk_o("err_enter", O_ERR);
        tick();
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("err_held", O_ERR);
        chk_cnt("err");
        RESET = 1'b1;
        #1;
        ld_exp = 0;
        br_exp = 0;
        chk_o("err_reset", O_RUN);
        chk_cnt("err_reset");
        RESET = 1'b0;
        tick();
        drive(16'h0000, 1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("post_reset", O_RUN);
        tick();

        // Reset in the middle of BR_WAIT aborts the branch at once
        drive(16'h0405, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
        chk_o("br4_detect", O_BRD);
        tick();
        drive(16'h1283, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0);
        chk_o("br4_wait", O_WAIT);
        RESET = 1'b1;
        #1;
        chk_o("wait_reset", O_RUN);
        chk_cnt("wait_reset");
        RESET = 1'b0;
        drive(16'h0000, 1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 1'b0);
        chk_o("nop_nostall", O_RUN);
        tick();
        chk_o("nop_next", O_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
